// File: rtl/tug_field_scored.sv
// tug_field_scored: parametrised tug-of-war playfield with round scoring.
//
// A single position register walks a lit LED between two players. Each press
// (rising edge of a key level) pulls the light one step toward that player.
// Pulling past the player's own end wins the round. The first player to
// WIN_SCORE rounds wins the match.
//
// Ports:
//   Clock        in   system clock, all state changes on the rising edge
//   Reset        in   synchronous, active-high
//   left_btn     in   left player key level, active-high
//   right_btn    in   right player key level, active-high
//   leds         out  playfield lights, index NUM_LIGHTS-1 is leftmost
//   score_left   out  rounds won by the left player
//   score_right  out  rounds won by the right player
//   round_winner out  2'b10 left won, 2'b01 right won, 2'b00 none / in play
//   match_over   out  high once either score reaches WIN_SCORE
module tug_field_scored #(
    parameter int unsigned NUM_LIGHTS  = 9,
    parameter int unsigned SCORE_WIDTH = 3,
    parameter int unsigned WIN_SCORE   = 7
) (
    input  logic                   Clock,
    input  logic                   Reset,
    input  logic                   left_btn,
    input  logic                   right_btn,
    output logic [NUM_LIGHTS-1:0]  leds,
    output logic [SCORE_WIDTH-1:0] score_left,
    output logic [SCORE_WIDTH-1:0] score_right,
    output logic [1:0]             round_winner,
    output logic                   match_over
);

    localparam int unsigned             PosW    = $clog2(NUM_LIGHTS);
    localparam logic [PosW-1:0]         Center  = PosW'((NUM_LIGHTS - 1) / 2);
    localparam logic [PosW-1:0]         LeftEnd = PosW'(NUM_LIGHTS - 1);
    localparam logic [SCORE_WIDTH-1:0]  Win     = SCORE_WIDTH'(WIN_SCORE);

    typedef enum logic [1:0] {StPlay, StRoundEnd, StMatchEnd} state_e;

    state_e                 state_q, state_d;
    logic [PosW-1:0]        pos_q, pos_d;
    logic [SCORE_WIDTH-1:0] score_left_q, score_left_d;
    logic [SCORE_WIDTH-1:0] score_right_q, score_right_d;
    logic [SCORE_WIDTH-1:0] score_left_inc, score_right_inc;
    logic [1:0]             winner_q, winner_d;
    logic                   l_q, r_q;
    logic                   pl, pr;

    // Previous key levels load during reset too, so a key held through
    // reset release does not count as a press.
    always_ff @(posedge Clock) begin
        l_q <= left_btn;
        r_q <= right_btn;
        if (Reset) begin
            state_q       <= StPlay;
            pos_q         <= Center;
            score_left_q  <= '0;
            score_right_q <= '0;
            winner_q      <= 2'b00;
        end else begin
            state_q       <= state_d;
            pos_q         <= pos_d;
            score_left_q  <= score_left_d;
            score_right_q <= score_right_d;
            winner_q      <= winner_d;
        end
    end

    always_comb begin
        pl              = left_btn & ~l_q;
        pr              = right_btn & ~r_q;
        score_left_inc  = score_left_q + SCORE_WIDTH'(1);
        score_right_inc = score_right_q + SCORE_WIDTH'(1);
        state_d         = state_q;
        pos_d           = pos_q;
        score_left_d    = score_left_q;
        score_right_d   = score_right_q;
        winner_d        = winner_q;
        unique case (state_q)
            StPlay: begin
                // Simultaneous presses cancel out.
                if (pl && !pr) begin
                    if (pos_q == LeftEnd) begin
                        score_left_d = score_left_inc;
                        winner_d     = 2'b10;
                        state_d      = (score_left_inc == Win) ? StMatchEnd : StRoundEnd;
                    end else begin
                        pos_d = pos_q + PosW'(1);
                    end
                end else if (pr && !pl) begin
                    if (pos_q == '0) begin
                        score_right_d = score_right_inc;
                        winner_d      = 2'b01;
                        state_d       = (score_right_inc == Win) ? StMatchEnd : StRoundEnd;
                    end else begin
                        pos_d = pos_q - PosW'(1);
                    end
                end
            end
            StRoundEnd: begin
                if (pl || pr) begin
                    pos_d    = Center;
                    winner_d = 2'b00;
                    state_d  = StPlay;
                end
            end
            StMatchEnd: begin
                // Frozen until reset.
            end
            default: begin
                state_d = StPlay;
                pos_d   = Center;
            end
        endcase
    end

    always_comb begin
        leds = '0;
        unique case (state_q)
            StPlay:     leds = NUM_LIGHTS'(1) << pos_q;
            StRoundEnd: leds = '0;
            StMatchEnd: leds = '1;
            default:    leds = '0;
        endcase
    end

    assign score_left   = score_left_q;
    assign score_right  = score_right_q;
    assign round_winner = winner_q;
    assign match_over   = (state_q == StMatchEnd);

endmodule

// File: tb/tb_tug_field_scored.sv
// Self-checking bench for tug_field_scored. Two instances share the key
// inputs: the default 9-light / first-to-7 field and a 3-light / first-to-2
// field. A reference model tracks each field with plain integers and is
// compared against every output after every clock edge.
module tb_tug_field_scored;

    logic Clock;
    logic Reset;
    logic left_btn;
    logic right_btn;

    logic [8:0] leds0;
    logic [2:0] score_left0, score_right0;
    logic [1:0] round_winner0;
    logic       match_over0;

    logic [2:0] leds1;
    logic [2:0] score_left1, score_right1;
    logic [1:0] round_winner1;
    logic       match_over1;

    tug_field_scored #(
        .NUM_LIGHTS (9),
        .SCORE_WIDTH(3),
        .WIN_SCORE  (7)
    ) dut0 (
        .Clock       (Clock),
        .Reset       (Reset),
        .left_btn    (left_btn),
        .right_btn   (right_btn),
        .leds        (leds0),
        .score_left  (score_left0),
        .score_right (score_right0),
        .round_winner(round_winner0),
        .match_over  (match_over0)
    );

    tug_field_scored #(
        .NUM_LIGHTS (3),
        .SCORE_WIDTH(3),
        .WIN_SCORE  (2)
    ) dut1 (
        .Clock       (Clock),
        .Reset       (Reset),
        .left_btn    (left_btn),
        .right_btn   (right_btn),
        .leds        (leds1),
        .score_left  (score_left1),
        .score_right (score_right1),
        .round_winner(round_winner1),
        .match_over  (match_over1)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model, one slot per field.
    int n_lights[2] = '{9, 3};
    int win_at[2]   = '{7, 2};
    int pos[2];
    int sl[2];
    int sr[2];
    int winner[2];
    bit between_rounds[2];
    bit match_done[2];
    bit prev_l;
    bit prev_r;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int exp_leds(input int i);
        if (match_done[i]) return (1 << n_lights[i]) - 1;
        if (between_rounds[i]) return 0;
        return 1 << pos[i];
    endfunction

    task automatic model_edge(input bit l, input bit r, input bit rst);
        bit pl, pr;
        pl = l && !prev_l;
        pr = r && !prev_r;
        prev_l = l;
        prev_r = r;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                pos[i] = (n_lights[i] - 1) / 2;
                sl[i] = 0;
                sr[i] = 0;
                winner[i] = 0;
                between_rounds[i] = 0;
                match_done[i] = 0;
            end else if (match_done[i]) begin
                // nothing changes
            end else if (between_rounds[i]) begin
                if (pl || pr) begin
                    between_rounds[i] = 0;
                    pos[i] = (n_lights[i] - 1) / 2;
                    winner[i] = 0;
                end
            end else if (pl && !pr) begin
                if (pos[i] == n_lights[i] - 1) begin
                    sl[i]++;
                    winner[i] = 2;
                    if (sl[i] == win_at[i]) match_done[i] = 1;
                    else between_rounds[i] = 1;
                end else pos[i]++;
            end else if (pr && !pl) begin
                if (pos[i] == 0) begin
                    sr[i]++;
                    winner[i] = 1;
                    if (sr[i] == win_at[i]) match_done[i] = 1;
                    else between_rounds[i] = 1;
                end else pos[i]--;
            end
        end
    endtask

    task automatic check_all();
        check("leds0", 32'(leds0), 32'(exp_leds(0)));
        check("score_left0", 32'(score_left0), 32'(sl[0]));
        check("score_right0", 32'(score_right0), 32'(sr[0]));
        check("round_winner0", 32'(round_winner0), 32'(winner[0]));
        check("match_over0", 32'(match_over0), 32'(match_done[0]));
        check("leds1", 32'(leds1), 32'(exp_leds(1)));
        check("score_left1", 32'(score_left1), 32'(sl[1]));
        check("score_right1", 32'(score_right1), 32'(sr[1]));
        check("round_winner1", 32'(round_winner1), 32'(winner[1]));
        check("match_over1", 32'(match_over1), 32'(match_done[1]));
    endtask

    // Drive one clock worth of inputs, step the model at the edge, check 1 ns later.
    task automatic cycle(input bit l, input bit r, input bit rst);
        left_btn  = l;
        right_btn = r;
        Reset     = rst;
        @(posedge Clock);
        model_edge(l, r, rst);
        #1;
        check_all();
    endtask

    task automatic press(input bit l, input bit r, input int hold, input int gap);
        for (int k = 0; k < hold; k++) cycle(l, r, 1'b0);
        for (int k = 0; k < gap; k++) cycle(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        left_btn  = 1'b0;
        right_btn = 1'b0;
        Reset     = 1'b1;

        // Reset values.
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        check("reset_leds", 32'(leds0), 32'h010);
        cycle(1'b0, 1'b0, 1'b0);

        // Left walk to a round win.
        for (int p = 0; p < 5; p++) press(1'b1, 1'b0, 3, 2);
        check("left_win_leds", 32'(leds0), 32'h000);
        check("left_win_score", 32'(score_left0), 32'd1);
        check("left_win_winner", 32'(round_winner0), 32'h2);

        // Restart, long hold, then a simultaneous press.
        press(1'b0, 1'b1, 1, 2);
        check("restart_leds", 32'(leds0), 32'h010);
        press(1'b1, 1'b0, 20, 2);
        check("hold_once_leds", 32'(leds0), 32'h020);
        press(1'b1, 1'b1, 3, 2);
        check("simultaneous_leds", 32'(leds0), 32'h020);

        // Right presses to a right-side round win.
        for (int p = 0; p < 6; p++) press(1'b0, 1'b1, 1, 1);
        check("right_win_score", 32'(score_right0), 32'd1);
        check("right_win_winner", 32'(round_winner0), 32'h1);

        // Reset while the left key is held; no press until released.
        cycle(1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        check("held_through_reset", 32'(leds0), 32'h010);
        press(1'b0, 1'b0, 0, 1);
        press(1'b1, 1'b0, 1, 1);
        check("repress_after_reset", 32'(leds0), 32'h020);

        // Drive the small field to match end, then confirm it stays frozen.
        for (int p = 0; p < 8; p++) press(1'b1, 1'b0, 1, 1);
        check("small_match_over", 32'(match_over1), 32'd1);
        check("small_match_leds", 32'(leds1), 32'h7);
        press(1'b0, 1'b1, 1, 1);
        check("small_frozen_score", 32'(score_left1), 32'd2);

        // Random key activity with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 199) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
